// File: rtl/obi_pkg.sv
// Shared types for the OBI-to-SSRAM arbiter: default bus widths, the
// response-source enum and the tag carried alongside every memory access.
package obi_pkg;

    localparam int unsigned OBI_ADDR_WIDTH = 32;
    localparam int unsigned OBI_DATA_WIDTH = 32;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } obi_src_t;

    typedef struct packed {
        logic     valid;
        obi_src_t src;
        logic     we;
    } resp_tag_t;

endpackage

// File: rtl/resp_tag_pipe.sv
// Delay line of response tags matching the SSRAM read latency; the head tag
// lines up with mem_dout for the access that produced it.
module resp_tag_pipe
    import obi_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  resp_tag_t tag_i,
    output resp_tag_t tag_o
);

    resp_tag_t [RD_LATENCY-1:0] stage_q;
    resp_tag_t [RD_LATENCY-1:0] stage_d;

    generate
        if (RD_LATENCY > 1) begin : g_shift
            assign stage_d = {stage_q[RD_LATENCY-2:0], tag_i};
        end else begin : g_single
            assign stage_d = tag_i;
        end
    endgenerate

    // Clearing every stage on reset drops in-flight responses entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/obi_ssram_arbiter.sv
// Two-port OBI slave (fetch read-only, LSU read/write) sharing one
// single-port SSRAM, with starvation protection for the fetch port.
module obi_ssram_arbiter
    import obi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = OBI_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = OBI_DATA_WIDTH,
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    output logic                      i_gnt,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      i_rvalid,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    input  logic                      d_req,
    output logic                      d_gnt,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic                      d_we,
    input  logic [DATA_WIDTH/8-1:0]   d_be,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic                      d_rvalid,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      mem_csb,
    output logic                      mem_web,
    output logic [DATA_WIDTH/8-1:0]   mem_wmask,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_din,
    input  logic [DATA_WIDTH-1:0]     mem_dout
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0]       starve_q, starve_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     din_q, din_d;
    logic [BE_WIDTH-1:0]       wmask_q, wmask_d;
    logic                      fetch_forced;
    logic                      accept;
    logic [DATA_WIDTH-1:0]     read_data;
    resp_tag_t                 tag_in;
    resp_tag_t                 tag_head;
    logic                      unused_addr_bits;

    // Grants are gated by reset so nothing is accepted while rst is low.
    always_comb begin
        fetch_forced = (starve_q == STARVE_W'(STARVE_LIMIT));
        i_gnt        = rst & i_req & (~d_req | fetch_forced);
        d_gnt        = rst & d_req & ~(i_req & fetch_forced);
        accept       = i_gnt | d_gnt;
    end

    always_comb begin
        starve_d = starve_q;
        addr_d   = addr_q;
        din_d    = din_q;
        wmask_d  = wmask_q;
        tag_in   = '{valid: 1'b0, src: SRC_D, we: 1'b0};

        if (!i_req || i_gnt) begin
            starve_d = '0;
        end else if (!fetch_forced) begin
            starve_d = starve_q + 1'b1;
        end

        // Address/data/mask registers only move on acceptance so idle cycles don't toggle the macro pins.
        if (i_gnt) begin
            addr_d  = i_addr[MEM_ADDR_WIDTH+1:2];
            wmask_d = '0;
        end else if (d_gnt) begin
            addr_d  = d_addr[MEM_ADDR_WIDTH+1:2];
            wmask_d = d_we ? d_be : '0;
            if (d_we) begin
                din_d = d_wdata;
            end
        end

        tag_in = '{valid: accept, src: (i_gnt ? SRC_I : SRC_D), we: d_gnt & d_we};

        mem_csb   = ~accept;
        mem_web   = ~(d_gnt & d_we);
        mem_addr  = addr_d;
        mem_din   = din_d;
        mem_wmask = wmask_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            wmask_q  <= '0;
        end else begin
            starve_q <= starve_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            wmask_q  <= wmask_d;
        end
    end

    resp_tag_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_tag_pipe (
        .clk  (clk),
        .rst_n(rst),
        .tag_i(tag_in),
        .tag_o(tag_head)
    );

    // Writes still respond, but with zero data rather than whatever the macro outputs.
    always_comb begin
        read_data = (tag_head.valid && !tag_head.we) ? mem_dout : '0;
        i_rvalid  = tag_head.valid && (tag_head.src == SRC_I);
        d_rvalid  = tag_head.valid && (tag_head.src == SRC_D);
        i_rdata   = i_rvalid ? read_data : '0;
        d_rdata   = d_rvalid ? read_data : '0;
    end

    assign unused_addr_bits = ^{i_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], i_addr[1:0],
                                d_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], d_addr[1:0]};

endmodule

// File: tb/tb_obi_ssram_arbiter.sv
// Self-checking bench: behavioural SSRAM, a queue-based reference model of
// arbitration/responses, directed literal checks and a randomized phase.
module tb_obi_ssram_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MAW   = 10;
    localparam int RDL   = 2;
    localparam int LIMIT = 4;
    localparam int DEPTH = 1 << MAW;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic          i_gnt;
    logic [AW-1:0] i_addr;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_gnt;
    logic [AW-1:0] d_addr;
    logic          d_we;
    logic [3:0]    d_be;
    logic [DW-1:0] d_wdata;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_csb;
    logic          mem_web;
    logic [3:0]    mem_wmask;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int checkCount = 0;
    int errorCount = 0;

    obi_ssram_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_ADDR_WIDTH(MAW),
        .RD_LATENCY(RDL),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_gnt(i_gnt), .i_addr(i_addr),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_gnt(d_gnt), .d_addr(d_addr), .d_we(d_we),
        .d_be(d_be), .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SSRAM: masked writes, reads delivered RDL cycles after the request.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] dpipe [RDL];

    always @(posedge clk) begin
        for (int k = RDL - 1; k > 0; k--) dpipe[k] <= dpipe[k-1];
        if (!mem_csb && mem_web) dpipe[0] <= ram[mem_addr];
        else                     dpipe[0] <= $urandom;
        if (!mem_csb && !mem_web) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) ram[mem_addr][8*b +: 8] = mem_din[8*b +: 8];
        end
    end

    assign mem_dout = dpipe[RDL-1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: shadow memory plus a queue of responses keyed by due cycle.
    typedef struct {
        int            due;
        bit            isI;
        logic [DW-1:0] data;
    } respEntry_t;

    logic [DW-1:0] shadow [DEPTH];
    respEntry_t    respQ [$];
    int            cycleNo = 0;
    int            starveM = 0;
    bit            expI, expD;
    bit            expIValid, expDValid;
    logic [DW-1:0] expIData, expDData;
    int            idx;
    logic [MAW-1:0] lastAddr;
    logic [DW-1:0] lastDin;
    logic [3:0]    lastMask;
    bit            lastAddrKnown = 0, lastDinKnown = 0, lastMaskKnown = 1;

    always @(negedge clk) begin
        if (!rst) begin
            respQ.delete();
            starveM       = 0;
            lastAddrKnown = 0;
            lastDinKnown  = 0;
            lastMask      = 4'h0;
            lastMaskKnown = 1;
            checkOutput("model_rst_i_gnt", {31'b0, i_gnt}, 0);
            checkOutput("model_rst_d_gnt", {31'b0, d_gnt}, 0);
            checkOutput("model_rst_csb", {31'b0, mem_csb}, 1);
            checkOutput("model_rst_web", {31'b0, mem_web}, 1);
            checkOutput("model_rst_wmask", {28'b0, mem_wmask}, 0);
            checkOutput("model_rst_i_rvalid", {31'b0, i_rvalid}, 0);
            checkOutput("model_rst_d_rvalid", {31'b0, d_rvalid}, 0);
            checkOutput("model_rst_i_rdata", i_rdata, 0);
            checkOutput("model_rst_d_rdata", d_rdata, 0);
        end else begin
            expI = i_req && (!d_req || starveM == LIMIT);
            expD = d_req && !expI;
            checkOutput("model_i_gnt", {31'b0, i_gnt}, {31'b0, expI});
            checkOutput("model_d_gnt", {31'b0, d_gnt}, {31'b0, expD});
            checkOutput("model_csb", {31'b0, mem_csb}, {31'b0, !(expI || expD)});

            expIValid = 0; expDValid = 0; expIData = '0; expDData = '0;
            if (respQ.size() > 0 && respQ[0].due == cycleNo) begin
                if (respQ[0].isI) begin expIValid = 1; expIData = respQ[0].data; end
                else              begin expDValid = 1; expDData = respQ[0].data; end
                void'(respQ.pop_front());
            end
            checkOutput("model_i_rvalid", {31'b0, i_rvalid}, {31'b0, expIValid});
            checkOutput("model_d_rvalid", {31'b0, d_rvalid}, {31'b0, expDValid});
            checkOutput("model_i_rdata", i_rdata, expIData);
            checkOutput("model_d_rdata", d_rdata, expDData);

            if (expI) begin
                idx = int'(i_addr[MAW+1:2]);
                checkOutput("model_fetch_addr", {22'b0, mem_addr}, idx);
                checkOutput("model_fetch_web", {31'b0, mem_web}, 1);
                checkOutput("model_fetch_wmask", {28'b0, mem_wmask}, 0);
                respQ.push_back('{due: cycleNo + RDL, isI: 1'b1, data: shadow[idx]});
                lastAddr = MAW'(idx); lastAddrKnown = 1;
                lastMask = 4'h0; lastMaskKnown = 1; lastDinKnown = 0;
            end else if (expD) begin
                idx = int'(d_addr[MAW+1:2]);
                checkOutput("model_lsu_addr", {22'b0, mem_addr}, idx);
                checkOutput("model_lsu_web", {31'b0, mem_web}, {31'b0, !d_we});
                lastAddr = MAW'(idx); lastAddrKnown = 1;
                if (d_we) begin
                    checkOutput("model_lsu_wmask", {28'b0, mem_wmask}, {28'b0, d_be});
                    checkOutput("model_lsu_din", mem_din, d_wdata);
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) shadow[idx][8*b +: 8] = d_wdata[8*b +: 8];
                    respQ.push_back('{due: cycleNo + RDL, isI: 1'b0, data: '0});
                    lastMask = d_be; lastMaskKnown = 1;
                    lastDin = d_wdata; lastDinKnown = 1;
                end else begin
                    respQ.push_back('{due: cycleNo + RDL, isI: 1'b0, data: shadow[idx]});
                    lastMaskKnown = 0; lastDinKnown = 0;
                end
            end else begin
                checkOutput("model_idle_web", {31'b0, mem_web}, 1);
                if (lastAddrKnown) checkOutput("model_idle_addr_hold", {22'b0, mem_addr}, {22'b0, lastAddr});
                if (lastDinKnown)  checkOutput("model_idle_din_hold", mem_din, lastDin);
                if (lastMaskKnown) checkOutput("model_idle_wmask_hold", {28'b0, mem_wmask}, {28'b0, lastMask});
            end

            if (!i_req || expI)      starveM = 0;
            else if (starveM < LIMIT) starveM++;
        end
        cycleNo++;
    end

    // Drive one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic rstVal, input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [31:0] da,
                                 input logic [3:0] be, input logic [31:0] wd);
        @(posedge clk);
        #1;
        rst = rstVal; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_be = be; d_wdata = wd;
        @(negedge clk);
    endtask

    task automatic preload(input int index, input logic [31:0] value);
        ram[index]    = value;
        shadow[index] = value;
    endtask

    bit starvePat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit holdI, holdD;
        logic ir, dr, dw, rv;
        logic [31:0] ia, da, wd;
        logic [3:0] be;

        rst = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wdata = 0;
        for (int k = 0; k < DEPTH; k++) preload(k, $urandom);
        for (int k = 0; k < RDL; k++) dpipe[k] = '0;

        $display("[TB] reset with both requests held");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 32'h0, 1, 0, 32'h4, 4'hF, 32'h0);
            checkOutput("rst_i_gnt", {31'b0, i_gnt}, 0);
            checkOutput("rst_d_gnt", {31'b0, d_gnt}, 0);
            checkOutput("rst_csb", {31'b0, mem_csb}, 1);
            checkOutput("rst_web", {31'b0, mem_web}, 1);
        end
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] masked write then read-back");
        preload(4, 32'h11223344);
        applyStimulus(1, 0, 0, 1, 1, 32'h10, 4'b0011, 32'hDEADBEEF);
        checkOutput("wr_d_gnt", {31'b0, d_gnt}, 1);
        checkOutput("wr_mem_addr", {22'b0, mem_addr}, 4);
        checkOutput("wr_mem_web", {31'b0, mem_web}, 0);
        checkOutput("wr_mem_wmask", {28'b0, mem_wmask}, 4'b0011);
        checkOutput("wr_mem_din", mem_din, 32'hDEADBEEF);
        applyStimulus(1, 0, 0, 1, 0, 32'h10, 4'h0, 32'h0);
        checkOutput("rd_mem_web", {31'b0, mem_web}, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_resp_valid", {31'b0, d_rvalid}, 1);
        checkOutput("wr_resp_data", d_rdata, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_resp_valid", {31'b0, d_rvalid}, 1);
        checkOutput("rd_resp_data", d_rdata, 32'h1122BEEF);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_resp_done", {31'b0, d_rvalid}, 0);

        $display("[TB] back-to-back fetch stream");
        preload(0, 32'hA0000000); preload(1, 32'hA1111111); preload(2, 32'hA2222222);
        applyStimulus(1, 1, 32'h0, 0, 0, 0, 0, 0);
        checkOutput("fs0_i_gnt", {31'b0, i_gnt}, 1);
        applyStimulus(1, 1, 32'h4, 0, 0, 0, 0, 0);
        checkOutput("fs1_i_gnt", {31'b0, i_gnt}, 1);
        checkOutput("fs1_i_rvalid", {31'b0, i_rvalid}, 0);
        applyStimulus(1, 1, 32'h8, 0, 0, 0, 0, 0);
        checkOutput("fs2_i_gnt", {31'b0, i_gnt}, 1);
        checkOutput("fs2_i_rvalid", {31'b0, i_rvalid}, 1);
        checkOutput("fs2_i_rdata", i_rdata, 32'hA0000000);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fs3_i_rdata", i_rdata, 32'hA1111111);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fs4_i_rdata", i_rdata, 32'hA2222222);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fs5_i_rvalid", {31'b0, i_rvalid}, 0);

        $display("[TB] starvation pattern");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 1, 32'h20, 1, 0, 32'h24, 4'h0, 32'h0);
            checkOutput("starve_i_gnt", {31'b0, i_gnt}, {31'b0, starvePat[k]});
            checkOutput("starve_d_gnt", {31'b0, d_gnt}, {31'b0, !starvePat[k]});
        end
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] interleaved fetch/LSU routing");
        preload(12, 32'h12121212); preload(13, 32'h13131313); preload(14, 32'h14141414);
        applyStimulus(1, 1, 32'h30, 0, 0, 0, 0, 0);
        checkOutput("il0_i_gnt", {31'b0, i_gnt}, 1);
        applyStimulus(1, 0, 0, 1, 0, 32'h34, 4'h0, 32'h0);
        checkOutput("il1_d_gnt", {31'b0, d_gnt}, 1);
        applyStimulus(1, 1, 32'h38, 0, 0, 0, 0, 0);
        checkOutput("il2_i_rvalid", {31'b0, i_rvalid}, 1);
        checkOutput("il2_d_rvalid", {31'b0, d_rvalid}, 0);
        checkOutput("il2_i_rdata", i_rdata, 32'h12121212);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("il3_i_rvalid", {31'b0, i_rvalid}, 0);
        checkOutput("il3_d_rvalid", {31'b0, d_rvalid}, 1);
        checkOutput("il3_d_rdata", d_rdata, 32'h13131313);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("il4_i_rvalid", {31'b0, i_rvalid}, 1);
        checkOutput("il4_d_rvalid", {31'b0, d_rvalid}, 0);
        checkOutput("il4_i_rdata", i_rdata, 32'h14141414);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset with reads in flight");
        applyStimulus(1, 0, 0, 1, 0, 32'h40, 4'h0, 32'h0);
        applyStimulus(1, 0, 0, 1, 0, 32'h44, 4'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("flush_rst_d_rvalid", {31'b0, d_rvalid}, 0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("flush_d_rvalid", {31'b0, d_rvalid}, 0);
            checkOutput("flush_i_rvalid", {31'b0, i_rvalid}, 0);
        end
        preload(20, 32'h50505050);
        applyStimulus(1, 0, 0, 1, 0, 32'h50, 4'h0, 32'h0);
        checkOutput("post_rst_d_gnt", {31'b0, d_gnt}, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_early", {31'b0, d_rvalid}, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_d_rvalid", {31'b0, d_rvalid}, 1);
        checkOutput("post_rst_d_rdata", d_rdata, 32'h50505050);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            holdI = i_req && !i_gnt;
            holdD = d_req && !d_gnt;
            rv = (rst == 1'b0) ? 1'b1 : ($urandom_range(0, 299) != 0);
            if (holdI) begin ir = i_req; ia = i_addr; end
            else begin
                ir = ($urandom_range(0, 9) < 7);
                ia = $urandom & 32'hFFFF_F03F;
            end
            if (holdD) begin dr = d_req; dw = d_we; da = d_addr; be = d_be; wd = d_wdata; end
            else begin
                dr = ($urandom_range(0, 9) < 7);
                dw = $urandom_range(0, 1);
                da = $urandom & 32'hFFFF_F03F;
                be = 4'($urandom);
                wd = $urandom;
            end
            applyStimulus(rv, ir, ia, dr, dw, da, be, wd);
        end
        for (int k = 0; k < RDL + 2; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
